// File: rtl/tnew_tuse_hazard_ctrl.sv
// tnew_tuse_hazard_ctrl
//
// Scoreboard-based hazard and forwarding controller for a 5-stage MIPS pipeline
// (F/D/E/M/W). Each in-flight instruction in E, M and W carries its destination
// register and a Tnew countdown: the number of cycles until its result can be
// forwarded. Each D-stage operand carries a Tuse deadline: the number of cycles
// until the operand is consumed. D stalls whenever the youngest in-flight
// producer of an operand cannot deliver it by that deadline.
//
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   rs_d, rt_d          D-stage source register indices
//   tuse_rs_d/rt_d      cycles from D until the operand is needed (all-ones = unused)
//   wr_d, tnew_d        D-stage destination (0 = none) and its Tnew on entering E
//   md_d                D instruction needs the multiply/divide unit
//   md_busy, md_start   MDU busy / starting this cycle
//   flush               kill everything in E, M and W
//   freeze              hold every stage register (e.g. memory wait)
//   stall, clear_e      hold F/D and insert a bubble into E
//   fwd_rs_d, fwd_rt_d  D bypass select: 0 regfile, 1 E, 2 M, 3 W
//   fwd_rs_e, fwd_rt_e  E bypass select: 0 pipe, 2 M, 3 W
//   fwd_rt_m            M bypass select: 0 pipe, 1 W
//   stall_cnt           saturating count of stall cycles that actually took effect

module tnew_tuse_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned T_W    = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [T_W-1:0]    tuse_rs_d,
  input  logic [T_W-1:0]    tuse_rt_d,
  input  logic [REG_AW-1:0] wr_d,
  input  logic [T_W-1:0]    tnew_d,
  input  logic              md_d,
  input  logic              md_busy,
  input  logic              md_start,
  input  logic              flush,
  input  logic              freeze,
  output logic              stall,
  output logic              clear_e,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [T_W-1:0] TuseUnused = '1;

  // Source codes shared by the D-stage select and the youngest-match search.
  localparam logic [1:0] SrcNone = 2'd0;
  localparam logic [1:0] SrcE    = 2'd1;
  localparam logic [1:0] SrcM    = 2'd2;
  localparam logic [1:0] SrcW    = 2'd3;

  // ---------------------------------------------------------------------------
  // Stage scoreboard
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] wr_e_q, wr_e_d;
  logic [T_W-1:0]    tnew_e_q, tnew_e_d;
  logic [REG_AW-1:0] rs_e_q, rs_e_d;
  logic [REG_AW-1:0] rt_e_q, rt_e_d;
  logic [REG_AW-1:0] wr_m_q, wr_m_d;
  logic [T_W-1:0]    tnew_m_q, tnew_m_d;
  logic [REG_AW-1:0] rt_m_q, rt_m_d;
  logic [REG_AW-1:0] wr_w_q, wr_w_d;
  logic [T_W-1:0]    tnew_w_q, tnew_w_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Youngest in-flight producer of register r. r == 0 never matches, so a match
  // always implies a real destination.
  function automatic logic [1:0] youngest_src(input logic [REG_AW-1:0] r,
                                              input logic [REG_AW-1:0] we,
                                              input logic [REG_AW-1:0] wm,
                                              input logic [REG_AW-1:0] ww);
    if (r == '0) begin
      return SrcNone;
    end else if (r == we) begin
      return SrcE;
    end else if (r == wm) begin
      return SrcM;
    end else if (r == ww) begin
      return SrcW;
    end
    return SrcNone;
  endfunction

  function automatic logic [T_W-1:0] src_tnew(input logic [1:0]     src,
                                               input logic [T_W-1:0] te,
                                               input logic [T_W-1:0] tm,
                                               input logic [T_W-1:0] tw);
    case (src)
      SrcE:    return te;
      SrcM:    return tm;
      SrcW:    return tw;
      default: return '0;
    endcase
  endfunction

  // D bypass: only the youngest producer counts. If it is not ready yet the
  // operand is read from the regfile and fixed up later by E/M forwarding.
  // W results are always final, so tnew_W is ignored there.
  function automatic logic [1:0] d_fwd_sel(input logic [1:0]     src,
                                           input logic [T_W-1:0] tnew);
    if (src == SrcW) begin
      return SrcW;
    end else if (src != SrcNone && tnew == '0) begin
      return src;
    end
    return SrcNone;
  endfunction

  // E bypass: ready M result first, otherwise whatever W holds.
  function automatic logic [1:0] e_fwd_sel(input logic [REG_AW-1:0] r,
                                           input logic [REG_AW-1:0] wm,
                                           input logic [T_W-1:0]    tm,
                                           input logic [REG_AW-1:0] ww);
    if (r == '0) begin
      return 2'd0;
    end else if (r == wm && tm == '0) begin
      return 2'd2;
    end else if (r == ww) begin
      return 2'd3;
    end
    return 2'd0;
  endfunction

  function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection and forwarding selects
  // ---------------------------------------------------------------------------
  logic [1:0]     rs_src, rt_src;
  logic [T_W-1:0] rs_tnew, rt_tnew;
  logic           rs_haz, rt_haz, md_haz;

  always_comb begin
    rs_src  = youngest_src(rs_d, wr_e_q, wr_m_q, wr_w_q);
    rt_src  = youngest_src(rt_d, wr_e_q, wr_m_q, wr_w_q);
    rs_tnew = src_tnew(rs_src, tnew_e_q, tnew_m_q, tnew_w_q);
    rt_tnew = src_tnew(rt_src, tnew_e_q, tnew_m_q, tnew_w_q);

    rs_haz  = (rs_src != SrcNone) && (tuse_rs_d != TuseUnused) && (rs_tnew > tuse_rs_d);
    rt_haz  = (rt_src != SrcNone) && (tuse_rt_d != TuseUnused) && (rt_tnew > tuse_rt_d);
    md_haz  = md_d && (md_busy || md_start);

    stall    = rs_haz || rt_haz || md_haz;
    clear_e  = stall;

    fwd_rs_d = d_fwd_sel(rs_src, rs_tnew);
    fwd_rt_d = d_fwd_sel(rt_src, rt_tnew);
    fwd_rs_e = e_fwd_sel(rs_e_q, wr_m_q, tnew_m_q, wr_w_q);
    fwd_rt_e = e_fwd_sel(rt_e_q, wr_m_q, tnew_m_q, wr_w_q);
    fwd_rt_m = (rt_m_q != '0) && (rt_m_q == wr_w_q);

    stall_cnt = stall_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state: flush > freeze > stall > advance (Reset handled in the register)
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_e_d      = wr_e_q;
    tnew_e_d    = tnew_e_q;
    rs_e_d      = rs_e_q;
    rt_e_d      = rt_e_q;
    wr_m_d      = wr_m_q;
    tnew_m_d    = tnew_m_q;
    rt_m_d      = rt_m_q;
    wr_w_d      = wr_w_q;
    tnew_w_d    = tnew_w_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      wr_e_d   = '0;
      tnew_e_d = '0;
      rs_e_d   = '0;
      rt_e_d   = '0;
      wr_m_d   = '0;
      tnew_m_d = '0;
      rt_m_d   = '0;
      wr_w_d   = '0;
      tnew_w_d = '0;
    end else if (!freeze) begin
      wr_m_d   = wr_e_q;
      tnew_m_d = dec_sat(tnew_e_q);
      rt_m_d   = rt_e_q;
      wr_w_d   = wr_m_q;
      tnew_w_d = dec_sat(tnew_m_q);
      if (stall) begin
        wr_e_d   = '0;
        tnew_e_d = '0;
        rs_e_d   = '0;
        rt_e_d   = '0;
      end else begin
        wr_e_d   = wr_d;
        tnew_e_d = tnew_d;
        rs_e_d   = rs_d;
        rt_e_d   = rt_d;
      end
      // Only stalls that actually hold the pipeline are counted.
      if (stall && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_e_q      <= '0;
      tnew_e_q    <= '0;
      rs_e_q      <= '0;
      rt_e_q      <= '0;
      wr_m_q      <= '0;
      tnew_m_q    <= '0;
      rt_m_q      <= '0;
      wr_w_q      <= '0;
      tnew_w_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_e_q      <= wr_e_d;
      tnew_e_q    <= tnew_e_d;
      rs_e_q      <= rs_e_d;
      rt_e_q      <= rt_e_d;
      wr_m_q      <= wr_m_d;
      tnew_m_q    <= tnew_m_d;
      rt_m_q      <= rt_m_d;
      wr_w_q      <= wr_w_d;
      tnew_w_q    <= tnew_w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_tnew_tuse_hazard_ctrl.sv
// Directed bench for tnew_tuse_hazard_ctrl. Instantiated with a 4-bit stall
// counter so saturation is reachable quickly.

module tb_tnew_tuse_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned T_W    = 2;
  localparam int unsigned CNT_W  = 4;

  logic              Clk;
  logic              Reset;
  logic [REG_AW-1:0] rs_d, rt_d, wr_d;
  logic [T_W-1:0]    tuse_rs_d, tuse_rt_d, tnew_d;
  logic              md_d, md_busy, md_start, flush, freeze;
  logic              stall, clear_e, fwd_rt_m;
  logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  tnew_tuse_hazard_ctrl #(
    .REG_AW (REG_AW),
    .T_W    (T_W),
    .CNT_W  (CNT_W)
  ) u_dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .tuse_rs_d (tuse_rs_d),
    .tuse_rt_d (tuse_rt_d),
    .wr_d      (wr_d),
    .tnew_d    (tnew_d),
    .md_d      (md_d),
    .md_busy   (md_busy),
    .md_start  (md_start),
    .flush     (flush),
    .freeze    (freeze),
    .stall     (stall),
    .clear_e   (clear_e),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e),
    .fwd_rt_m  (fwd_rt_m),
    .stall_cnt (stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_d(input logic [REG_AW-1:0] rs, input logic [T_W-1:0] trs,
                       input logic [REG_AW-1:0] rt, input logic [T_W-1:0] trt,
                       input logic [REG_AW-1:0] wr, input logic [T_W-1:0] tn);
    rs_d = rs; tuse_rs_d = trs; rt_d = rt; tuse_rt_d = trt; wr_d = wr; tnew_d = tn;
    #1;
  endtask

  task automatic nop_d();
    md_d = 1'b0; md_busy = 1'b0; md_start = 1'b0;
    set_d(0, 3, 0, 3, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1; flush = 1'b0; freeze = 1'b0;
    nop_d();
    tick();
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"},    32'(stall),     0);
    check({tag, ".clear_e"},  32'(clear_e),   0);
    check({tag, ".fwd_rs_d"}, 32'(fwd_rs_d),  0);
    check({tag, ".fwd_rt_d"}, 32'(fwd_rt_d),  0);
    check({tag, ".fwd_rs_e"}, 32'(fwd_rs_e),  0);
    check({tag, ".fwd_rt_e"}, 32'(fwd_rt_e),  0);
    check({tag, ".fwd_rt_m"}, 32'(fwd_rt_m),  0);
    check({tag, ".cnt"},      32'(stall_cnt), 0);
  endtask

  initial begin
    do_reset();
    check_all_zero("reset");

    // Load-use: producer in E with Tnew 2, consumer needs rs in 1 cycle.
    set_d(1, 3, 2, 3, 8, 2);
    tick();
    set_d(8, 1, 0, 3, 9, 1);
    check("lu.stall", 32'(stall), 1);
    check("lu.clear_e", 32'(clear_e), 1);
    tick();
    check("lu.stall2", 32'(stall), 0);
    check("lu.fwd_rs_d", 32'(fwd_rs_d), 0);
    check("lu.cnt", 32'(stall_cnt), 1);
    tick();
    nop_d();
    check("lu.fwd_rs_e", 32'(fwd_rs_e), 3);

    // ALU result feeding a branch in D.
    do_reset();
    set_d(0, 3, 0, 3, 3, 1);
    tick();
    set_d(3, 0, 0, 3, 0, 0);
    check("br.stall", 32'(stall), 1);
    tick();
    check("br.stall2", 32'(stall), 0);
    check("br.fwd_rs_d", 32'(fwd_rs_d), 2);
    do_reset();
    set_d(0, 3, 0, 3, 3, 1);
    tick();
    set_d(0, 0, 0, 3, 0, 0);
    check("br0.stall", 32'(stall), 0);
    check("br0.fwd_rs_d", 32'(fwd_rs_d), 0);

    // Youngest match wins, then E and M bypass.
    do_reset();
    set_d(0, 3, 0, 3, 5, 1);
    tick();
    set_d(0, 3, 0, 3, 5, 0);
    tick();                                  // E = 5/0, M = 5/0
    set_d(0, 3, 5, 0, 0, 0);
    check("yg.stall", 32'(stall), 0);
    check("yg.fwd_rt_d", 32'(fwd_rt_d), 1);
    tick();                                  // E rt=5, M = 5/0, W = 5
    nop_d();
    check("yg.fwd_rt_e", 32'(fwd_rt_e), 2);
    check("yg.fwd_rs_e", 32'(fwd_rs_e), 0);
    tick();                                  // M rt=5, W = 5
    check("yg.fwd_rt_m", 32'(fwd_rt_m), 1);
    check("yg.fwd_rt_e_nop", 32'(fwd_rt_e), 0);

    // MDU stall for 4 cycles.
    do_reset();
    md_d = 1'b1; md_busy = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("md.stall%0d", i), 32'(stall), 1);
      tick();
    end
    md_d = 1'b0; md_busy = 1'b0; #1;
    check("md.cnt", 32'(stall_cnt), 4);
    check("md.stall_off", 32'(stall), 0);
    md_d = 1'b1; md_start = 1'b1; #1;
    check("md.start", 32'(stall), 1);
    md_d = 1'b0; md_busy = 1'b1; md_start = 1'b0; #1;
    check("md.not_md", 32'(stall), 0);

    // MDU stall with freeze on the first two of four cycles.
    do_reset();
    set_d(0, 3, 0, 3, 7, 2);
    tick();                                  // E = 7/2
    set_d(0, 3, 0, 3, 0, 0);
    md_d = 1'b1; md_busy = 1'b1; freeze = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("fz.stall%0d", i), 32'(stall), 1);
      tick();
    end
    check("fz.cnt_held", 32'(stall_cnt), 0);
    md_d = 1'b0; freeze = 1'b0;
    set_d(7, 1, 0, 3, 0, 0);
    check("fz.state_held", 32'(stall), 1);   // E still 7/2
    md_d = 1'b1;
    set_d(0, 3, 0, 3, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("fz.stall_run%0d", i), 32'(stall), 1);
      tick();
    end
    check("fz.cnt", 32'(stall_cnt), 2);

    // Flush during an active load-use hazard.
    do_reset();
    set_d(0, 3, 0, 3, 8, 2);
    tick();
    set_d(8, 1, 0, 3, 0, 0);
    check("fl.stall", 32'(stall), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check("fl.stall_after", 32'(stall), 0);
    check("fl.cnt", 32'(stall_cnt), 0);
    set_d(8, 0, 8, 0, 0, 0);
    check("fl.no_prod", 32'(stall), 0);      // M/W were killed too
    check("fl.fwd_rs_d", 32'(fwd_rs_d), 0);
    check("fl.fwd_rs_e", 32'(fwd_rs_e), 0);

    // Saturation, then reset while stalled.
    do_reset();
    md_d = 1'b1; md_busy = 1'b1; #1;
    for (int i = 0; i < 20; i++) tick();
    check("sat.cnt", 32'(stall_cnt), 15);
    check("sat.stall", 32'(stall), 1);
    md_d = 1'b0;
    set_d(0, 3, 0, 3, 4, 0);
    tick();
    set_d(0, 3, 4, 3, 0, 0);
    tick();                                  // E rt=4, M = 4/0
    set_d(4, 3, 0, 3, 0, 0);
    check("sat.fwd_rt_e", 32'(fwd_rt_e), 2);
    check("sat.fwd_rs_d", 32'(fwd_rs_d), 2);
    md_d = 1'b1; #1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    nop_d();
    check_all_zero("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tnew_tuse_hazard_ctrl.md
Name: tnew_tuse_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Replaces fixed instruction-class hazard tables with a scoreboard: each in-flight instruction carries its destination register and a Tnew countdown; each D-stage operand carries a Tuse deadline.
- Generates the F/D stall, the E bubble, the D/E/M forwarding selects, and a saturating stall-cycle counter.
- Adds pipeline flush (exception/eret) and an external freeze (memory wait), neither of which the previous generation had.

Parameters:
- REG_AW, 5, register-address width.
- T_W, 2, width of Tnew/Tuse; Tuse all-ones means "operand unused".
- CNT_W, 32, width of the stall counter.

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- rs_d  in  REG_AW  D-stage rs index
- rt_d  in  REG_AW  D-stage rt index
- tuse_rs_d  in  T_W  cycles from D until rs needed (0 = in D)
- tuse_rt_d  in  T_W  same for rt
- wr_d  in  REG_AW  D-stage destination (0 = none)
- tnew_d  in  T_W  cycles after entering E until result forwardable
- md_d  in  1  D instruction uses the multiply/divide unit
- md_busy  in  1  MDU busy
- md_start  in  1  MDU starting this cycle
- flush  in  1  kill E, M, W entries
- freeze  in  1  hold whole pipeline
- stall  out  1  hold F and D
- clear_e  out  1  insert bubble into E (equals stall)
- fwd_rs_d  out  2  0 = regfile, 1 = E, 2 = M, 3 = W
- fwd_rt_d  out  2  same encoding
- fwd_rs_e  out  2  0 = pipe, 2 = M, 3 = W
- fwd_rt_e  out  2  same encoding
- fwd_rt_m  out  1  0 = pipe, 1 = W
- stall_cnt  out  CNT_W  stall cycles counted

Behaviour:
- State per stage S in {E, M, W}: wr_S, tnew_S, plus rs_E, rt_E and rt_M. A bubble has wr = 0, tnew = 0, rs = rt = 0.
- Reset: all stages become bubbles and stall_cnt = 0. Every output is therefore 0 in the cycle after reset.
- Update priority per edge: Reset > flush > freeze > stall > normal advance.
  - normal advance: E <= D inputs. M <= E with tnew_M = max(tnew_E − 1, 0). W <= M with tnew decremented the same way.
  - stall: E <= bubble. M and W advance as in normal advance.
  - freeze: every stage register holds; no decrement.
  - flush: E, M and W all become bubbles (the excepting instruction and everything younger never write back).
- Operand hazard (rs or rt in D), evaluated only when reg != 0 and Tuse != all-ones:
  - Find the youngest stage k among E, M, W with wr_k == reg.
  - Hazard if tnew_k > Tuse.
  - Older matches are ignored.
- MDU hazard = md_d && (md_busy || md_start).
- stall = rs hazard || rt hazard || MDU hazard. The signal is combinational, and it is valid during freeze and flush, but those take precedence at the edge.
- D forwarding select:
  - Pick the youngest matching stage with wr != 0 and tnew == 0.
  - If the youngest match has tnew > 0, output 0; E/M forwarding corrects the value later.
  - reg == 0 always gives 0.
- E forwarding (rs_E, rt_E): M if wr_M matches and tnew_M == 0, else W if wr_W matches, else 0. M has priority over W.
- M forwarding (rt_M): 1 if wr_W == rt_M != 0, else 0.
- tnew_W is always 0 for legal encodings. Forwarding from W ignores tnew_W.
- stall_cnt increments by 1 on an edge where stall && !freeze && !flush && !Reset. It saturates at all-ones; no wrap.

Test Plan:
- Load-use: E holds wr = 8, tnew = 2; D has rs = 8, tuse = 1 → stall = clear_e = 1 for exactly 1 cycle. Next cycle M has tnew = 1, still > 1? No, 1 > 1 is false → no stall, fwd_rs_d = 0, and the following cycle fwd_rs_e = 3 (W).
- ALU-to-branch: wr_E = 3 with tnew = 1 and rs_d = 3, tuse = 0 → 1 stall cycle, then fwd_rs_d = 2 (M). Repeat with rs_d = 0 → no stall, fwd = 0.
- Youngest match wins: E and M both write 5, E with tnew = 0 (jal) → fwd_rt_d = 1, not 2.
- MDU: md_d = 1 with md_busy held high for 4 cycles → stall high for 4 cycles and stall_cnt += 4. A freeze during 2 of those cycles → counter += 2 only, and all stage state holds.
- Flush mid-stall: wr_E = 8, tnew = 2, hazard active, flush = 1 → next cycle all stages are bubbles, stall = 0, and the counter is not incremented.
- Saturation: CNT_W = 4 with stall held high for 20 cycles → stall_cnt sticks at 15. Then Reset mid-stall → stall_cnt = 0 and all forwarding selects = 0 the next cycle.
